rx_cmd_parser: RTL and testbench
================================

Name: rx_cmd_parser

Overview:
- Command-frame parser directly downstream of the UART receiver.
- Consumes each received byte (P_Data qualified by Data_valid) and assembles multi-byte command frames.
- Issues single-cycle register-file write/read strobes and ALU-enable strobes to the system datapath.
- Aborts frames on receiver parity/stop errors, unknown opcodes and (optionally) inter-byte timeout.

Parameters:
- ADDR_W, 4, register-file address width; the address byte is truncated to its low ADDR_W bits.
- TIMEOUT_CYC, 2000, maximum idle CLK cycles allowed between bytes of one frame (used only with the optional feature).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Rx_P_Data  in  8  received byte; valid only while Rx_Data_valid=1.
- Rx_Data_valid  in  1  one-cycle pulse per good byte.
- Rx_Parity_error  in  1  receiver parity error level.
- Rx_stop_error  in  1  receiver stop error level.
- RF_WrEn  out  1  register-file write strobe, one cycle.
- RF_RdEn  out  1  register-file read strobe, one cycle.
- RF_Address  out  ADDR_W  register-file address.
- RF_WrData  out  8  register-file write data.
- ALU_EN  out  1  ALU enable strobe, one cycle.
- ALU_FUN  out  4  ALU function code.
- Frame_error  out  1  one-cycle pulse when a frame is aborted.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Opcodes:
  - 0xAA RF write: frame is cmd, addr, data.
  - 0xBB RF read: frame is cmd, addr.
  - 0xCC ALU with operands: frame is cmd, opA, opB, fun.
  - 0xDD ALU without operands: frame is cmd, fun.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN. A state advances only on a cycle with Rx_Data_valid=1.
- IDLE transitions:
  - 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OPA; 0xDD -> FUN.
  - Any other byte: stay in IDLE and pulse Frame_error.
- Other transitions:
  - WR_ADDR: latch address -> WR_DATA.
  - WR_DATA: RF_WrEn=1 with the latched address and the byte -> IDLE.
  - RD_ADDR: RF_RdEn=1 with that address -> IDLE.
  - OPA: RF write of the byte to address 0 -> OPB.
  - OPB: RF write of the byte to address 1 -> FUN.
  - FUN: ALU_EN=1, ALU_FUN=byte[3:0] -> IDLE. Upper nibble is ignored.
- Latency and timing:
  - All outputs are registered.
  - Each strobe asserts in the cycle after the final byte's valid cycle and lasts exactly one cycle.
  - RF_Address, RF_WrData and ALU_FUN hold their last values between strobes.
- Error detection:
  - err_rise = rising edge of (Rx_Parity_error | Rx_stop_error), detected with one internal register.
  - err_rise in any state -> IDLE and a one-cycle Frame_error pulse. No strobe is issued for the partial frame.
  - err_rise in IDLE also pulses Frame_error.
- Simultaneous events:
  - err_rise and Rx_Data_valid in the same cycle: the error wins and the byte is discarded.
  - Writes already issued for opA/opB are not rolled back.
- Back-to-back frames: a new opcode byte is accepted the cycle immediately after the returning-to-IDLE valid cycle.
- Reset:
  - Asserting Reset at any point, including mid-frame, forces IDLE asynchronously.
  - All outputs go to 0: RF_WrEn, RF_RdEn, ALU_EN, Frame_error, Busy, RF_Address, RF_WrData, ALU_FUN.
  - The error-edge register resets to 0.

Optional Feature:
- Macro: RX_CMD_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on every Rx_Data_valid and while in IDLE, and increments in every other cycle.
  - When the count reaches TIMEOUT_CYC in a non-IDLE state, the FSM returns to IDLE and pulses Frame_error once. The counter saturates and does not wrap.
- When undefined: no counter exists, and a partial frame waits indefinitely.

Decomposition:
- Shared package rx_cmd_pkg contains:
  - opcode constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - the state encoding;
  - operand addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module, rx_frame_timer, holds the timeout counter and is instantiated only under RX_CMD_TIMEOUT_EN. Everything else stays in one module.

Test Plan:
- Bytes AA,05,3C with valid pulses spaced 10 cycles apart -> one RF_WrEn pulse with RF_Address=5, RF_WrData=0x3C; Busy high from the AA cycle+1 to the strobe cycle.
- Bytes BB,0F -> one RF_RdEn pulse with RF_Address=0xF; no RF_WrEn.
- Bytes CC,12,34,F3 -> RF_WrEn at addr 0 data 0x12, then at addr 1 data 0x34, then ALU_EN with ALU_FUN=3.
- Bytes AA,02, then Rx_Parity_error rises -> Frame_error pulses once, no RF_WrEn, FSM in IDLE; next DD,01 -> ALU_EN with ALU_FUN=1.
- Byte 0x55 in IDLE -> Frame_error pulse, Busy stays 0. Reset pulsed after CC,11 -> all outputs 0; the following DD,07 executes normally.
- With RX_CMD_TIMEOUT_EN and TIMEOUT_CYC=50: AA then silence -> Frame_error exactly 50 cycles after the AA valid cycle and return to IDLE. Without the macro -> no Frame_error.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the UART command-frame parser: opcodes, FSM encoding
// and the fixed register-file addresses used for ALU operands.
package rx_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        OPA     = 3'd4,
        OPB     = 3'd5,
        FUN     = 3'd6
    } state_e;

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte idle counter; flags expiry so the parser's registered
// Frame_error lands TIMEOUT_CYC cycles after the last accepted byte.
module rx_frame_timer #(
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // saturating count; never wraps back to a small value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (cnt_q != TW'(TIMEOUT_CYC))
            cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = !clr_i && (cnt_d >= TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rx_cmd_parser.sv
// Command-frame parser behind the UART receiver; issues RF/ALU strobes.
// Optional inter-byte timeout enabled by defining RX_CMD_TIMEOUT_EN.
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        Rx_P_Data,
    input  logic              Rx_Data_valid,
    input  logic              Rx_Parity_error,
    input  logic              Rx_stop_error,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [7:0]        RF_WrData,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    output logic              Frame_error,
    output logic              Busy
);
    state_e            state_q, state_d;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_d, rd_en_d, alu_en_d, frame_err_d;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [7:0]        wr_data_d;
    logic [3:0]        alu_fun_d;

    logic err_rise, byte_ok, idle, bad_op, timeout;

    assign err_rise = (Rx_Parity_error | Rx_stop_error) & ~err_q;
    assign byte_ok  = Rx_Data_valid & ~err_rise;
    assign idle     = (state_q == IDLE);
    assign bad_op   = !(Rx_P_Data inside {CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP});

`ifdef RX_CMD_TIMEOUT_EN
    rx_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk_i     (CLK),
        .rst_i     (Reset),
        .clr_i     (Rx_Data_valid | idle),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= Rx_Parity_error | Rx_stop_error;
        end
    end

    // a receiver error edge wins over a byte arriving in the same cycle
    always_comb begin
        state_d = state_q;
        if (err_rise || timeout) begin
            state_d = IDLE;
        end else if (Rx_Data_valid) begin
            unique case (state_q)
                IDLE: begin
                    case (Rx_P_Data)
                        CMD_RF_WR:   state_d = WR_ADDR;
                        CMD_RF_RD:   state_d = RD_ADDR;
                        CMD_ALU_OP:  state_d = OPA;
                        CMD_ALU_NOP: state_d = FUN;
                        default:     state_d = IDLE;
                    endcase
                end
                WR_ADDR: state_d = WR_DATA;
                WR_DATA: state_d = IDLE;
                RD_ADDR: state_d = IDLE;
                OPA:     state_d = OPB;
                OPB:     state_d = FUN;
                FUN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        rf_addr_d   = RF_Address;
        wr_data_d   = RF_WrData;
        alu_fun_d   = ALU_FUN;
        frame_err_d = err_rise | timeout | (byte_ok & idle & bad_op);
        if (byte_ok) begin
            case (state_q)
                WR_ADDR: addr_d = Rx_P_Data[ADDR_W-1:0];
                WR_DATA: begin
                    wr_en_d   = 1'b1;
                    rf_addr_d = addr_q;
                    wr_data_d = Rx_P_Data;
                end
                RD_ADDR: begin
                    rd_en_d   = 1'b1;
                    rf_addr_d = Rx_P_Data[ADDR_W-1:0];
                end
                OPA: begin
                    wr_en_d   = 1'b1;
                    rf_addr_d = ADDR_W'(OPA_ADDR);
                    wr_data_d = Rx_P_Data;
                end
                OPB: begin
                    wr_en_d   = 1'b1;
                    rf_addr_d = ADDR_W'(OPB_ADDR);
                    wr_data_d = Rx_P_Data;
                end
                FUN: begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = Rx_P_Data[3:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_q      <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_EN      <= 1'b0;
            Frame_error <= 1'b0;
            Busy        <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_FUN     <= '0;
        end else begin
            addr_q      <= addr_d;
            RF_WrEn     <= wr_en_d;
            RF_RdEn     <= rd_en_d;
            ALU_EN      <= alu_en_d;
            Frame_error <= frame_err_d;
            Busy        <= (state_d != IDLE);
            RF_Address  <= rf_addr_d;
            RF_WrData   <= wr_data_d;
            ALU_FUN     <= alu_fun_d;
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: stimulus pushes expected strobes,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_rx_cmd_parser;
    localparam int ADDR_W = 4;
    localparam int TO_CYC = 50;
    localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_ERR = 3;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic [7:0]        Rx_P_Data = 8'h00;
    logic              Rx_Data_valid = 1'b0;
    logic              Rx_Parity_error = 1'b0;
    logic              Rx_stop_error = 1'b0;
    logic              RF_WrEn, RF_RdEn, ALU_EN, Frame_error, Busy;
    logic [ADDR_W-1:0] RF_Address;
    logic [7:0]        RF_WrData;
    logic [3:0]        ALU_FUN;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    rx_cmd_parser #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(CLK), .Reset(Reset), .Rx_P_Data(Rx_P_Data), .Rx_Data_valid(Rx_Data_valid),
        .Rx_Parity_error(Rx_Parity_error), .Rx_stop_error(Rx_stop_error),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .Frame_error(Frame_error), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        Rx_P_Data = b;
        Rx_Data_valid = 1'b1;
        cyc(1);
        Rx_Data_valid = 1'b0;
        cyc(gap);
    endtask

    // monitor: every strobe must match the head of the expectation queue
    always @(negedge CLK) begin
        if (!Reset && (RF_WrEn || RF_RdEn || ALU_EN || Frame_error)) begin
            int act_kind;
            exp_t e;
            act_kind = RF_WrEn ? K_WR : RF_RdEn ? K_RD : ALU_EN ? K_ALU : K_ERR;
            chk("strobe_onehot", 32'(RF_WrEn + RF_RdEn + ALU_EN + Frame_error), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(act_kind), 32'hFFFF);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", 32'(act_kind), 32'(e.kind));
                if (e.kind == K_WR) begin
                    chk("wr_addr", 32'(RF_Address), 32'(e.addr));
                    chk("wr_data", 32'(RF_WrData), 32'(e.data));
                end else if (e.kind == K_RD) begin
                    chk("rd_addr", 32'(RF_Address), 32'(e.addr));
                end else if (e.kind == K_ALU) begin
                    chk("alu_fun", 32'(ALU_FUN), 32'(e.data[3:0]));
                end
            end
        end
    end

    initial begin
        cyc(3);
        chk("rst_outputs", {RF_WrEn, RF_RdEn, ALU_EN, Frame_error, Busy, RF_Address, RF_WrData, ALU_FUN}, 32'd0);
        @(posedge CLK); #1 Reset = 1'b0;
        cyc(2);

        // RF write with spaced bytes
        push(K_WR, 4'h5, 8'h3C);
        send(8'hAA, 10);
        chk("busy_mid_wr", 32'(Busy), 32'd1);
        send(8'h05, 10);
        chk("busy_mid_wr2", 32'(Busy), 32'd1);
        send(8'h3C, 3);
        chk("busy_after_wr", 32'(Busy), 32'd0);

        // RF read, back-to-back bytes
        push(K_RD, 4'hF, 8'h00);
        send(8'hBB, 0);
        send(8'h0F, 0);
        // ALU with operands: opcode immediately after the previous frame
        push(K_WR, 4'h0, 8'h12);
        push(K_WR, 4'h1, 8'h34);
        push(K_ALU, 4'h0, 8'hF3);
        send(8'hCC, 1);
        send(8'h12, 1);
        send(8'h34, 1);
        send(8'hF3, 3);
        chk("rd_addr_held", 32'(RF_Address), 32'h1);
        chk("wr_data_held", 32'(RF_WrData), 32'h34);

        // parity error mid-frame aborts; level held high does not re-pulse
        push(K_ERR, 4'h0, 8'h00);
        send(8'hAA, 2);
        send(8'h02, 2);
        Rx_Parity_error = 1'b1;
        cyc(4);
        chk("busy_after_abort", 32'(Busy), 32'd0);
        Rx_Parity_error = 1'b0;
        cyc(1);
        push(K_ALU, 4'h0, 8'h01);
        send(8'hDD, 1);
        send(8'h01, 3);

        // error edge and byte in the same cycle: byte dropped
        push(K_ERR, 4'h0, 8'h00);
        send(8'hAA, 2);
        Rx_stop_error = 1'b1;
        send(8'h09, 1);
        Rx_stop_error = 1'b0;
        cyc(1);
        push(K_RD, 4'h3, 8'h00);
        send(8'hBB, 1);
        send(8'h03, 3);

        // unknown opcode
        push(K_ERR, 4'h0, 8'h00);
        send(8'h55, 0);
        chk("busy_bad_op", 32'(Busy), 32'd0);
        cyc(3);

        // reset mid-frame clears every output, then normal operation
        push(K_WR, 4'h0, 8'h11);
        send(8'hCC, 1);
        send(8'h11, 3);
        #2 Reset = 1'b1;
        #1;
        chk("rst_mid_frame", {RF_WrEn, RF_RdEn, ALU_EN, Frame_error, Busy, RF_Address, RF_WrData, ALU_FUN}, 32'd0);
        @(posedge CLK); #1 Reset = 1'b0;
        cyc(1);
        chk("busy_after_rst", 32'(Busy), 32'd0);
        push(K_ALU, 4'h0, 8'h07);
        send(8'hDD, 1);
        send(8'h07, 3);

`ifdef RX_CMD_TIMEOUT_EN
        begin
            int n;
            push(K_ERR, 4'h0, 8'h00);
            send(8'hAA, 0);
            n = 1;
            while (!Frame_error && n < 3 * TO_CYC) begin
                cyc(1);
                n++;
            end
            chk("timeout_latency", 32'(n), 32'(TO_CYC));
            cyc(2);
            chk("busy_after_timeout", 32'(Busy), 32'd0);
        end
`else
        send(8'hAA, 2 * TO_CYC);
        chk("busy_no_timeout", 32'(Busy), 32'd1);
        push(K_ERR, 4'h0, 8'h00);
        Rx_Parity_error = 1'b1;
        cyc(2);
        Rx_Parity_error = 1'b0;
        cyc(1);
`endif

        cyc(5);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
